// File: rtl/ipif_fifo_sequencer_pkg.sv
// rtl/ipif_fifo_sequencer_pkg.sv - shared state encoding and default parameters for the FIFO sequencer
package ipif_seq_pkg;

    localparam int C_DWIDTH_DEF      = 32;
    localparam int C_ACK_TIMEOUT_DEF = 16;
    localparam int C_CNT_WIDTH_DEF   = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_REQ    = 3'd1,
        ST_START     = 3'd2,
        ST_CORE_WAIT = 3'd3,
        ST_WR_HOLD   = 3'd4,
        ST_WR_REQ    = 3'd5
    } seq_state_t;

    // True for the two states that wait on a FIFO acknowledge
    function automatic logic is_req_state(input seq_state_t s);
        return (s == ST_RD_REQ) || (s == ST_WR_REQ);
    endfunction

endpackage

// File: rtl/ipif_fifo_sequencer_if.sv
// rtl/ipif_fifo_sequencer_if.sv - IPIF FIFO, core and status signals between sequencer and its neighbours
interface ipif_fifo_sequencer_if
    import ipif_seq_pkg::*;
#(
    parameter int C_DWIDTH    = C_DWIDTH_DEF,
    parameter int C_CNT_WIDTH = C_CNT_WIDTH_DEF
);
    logic                    seq_enable;
    logic                    wfifo2ip_empty;
    logic                    wfifo2ip_rdack;
    logic [0:C_DWIDTH-1]     wfifo2ip_data;
    logic                    ip2wfifo_rdreq;
    logic                    rfifo2ip_full;
    logic                    rfifo2ip_wrack;
    logic                    ip2rfifo_wrreq;
    logic [0:C_DWIDTH-1]     ip2rfifo_data;
    logic                    core_start;
    logic [0:C_DWIDTH-1]     core_operand;
    logic                    core_done;
    logic [0:C_DWIDTH-1]     core_result;
    logic                    seq_busy;
    logic                    seq_err;
    logic [0:C_CNT_WIDTH-1]  words_in;
    logic [0:C_CNT_WIDTH-1]  words_out;

    modport master (
        input  seq_enable, wfifo2ip_empty, wfifo2ip_rdack, wfifo2ip_data,
        input  rfifo2ip_full, rfifo2ip_wrack, core_done, core_result,
        output ip2wfifo_rdreq, ip2rfifo_wrreq, ip2rfifo_data,
        output core_start, core_operand, seq_busy, seq_err, words_in, words_out
    );

    modport slave (
        output seq_enable, wfifo2ip_empty, wfifo2ip_rdack, wfifo2ip_data,
        output rfifo2ip_full, rfifo2ip_wrack, core_done, core_result,
        input  ip2wfifo_rdreq, ip2rfifo_wrreq, ip2rfifo_data,
        input  core_start, core_operand, seq_busy, seq_err, words_in, words_out
    );

endinterface

// File: rtl/ipif_fifo_sequencer_ack_timer.sv
// rtl/ipif_fifo_sequencer_ack_timer.sv - loadable down-counter bounding the wait for a FIFO acknowledge
module ipif_ack_timer
    import ipif_seq_pkg::*;
#(
    parameter int C_ACK_TIMEOUT = C_ACK_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expire
);
    localparam int              W        = $clog2(C_ACK_TIMEOUT);
    localparam logic [W-1:0]    LOAD_VAL = W'(C_ACK_TIMEOUT - 1);

    logic [W-1:0] r_count;
    logic         r_armed;

    // Load on request entry, count down once per waiting cycle, disarm once the request is gone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_armed <= 1'b0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
            r_armed <= 1'b1;
        end else if (i_clear) begin
            r_count <= '0;
            r_armed <= 1'b0;
        end else if (i_tick && r_armed && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Zero is reached in the C_ACK_TIMEOUT-th cycle of the request
    assign o_expire = r_armed && (r_count == '0);

endmodule

// File: rtl/ipif_fifo_sequencer.sv
// rtl/ipif_fifo_sequencer.sv - moves one word at a time from write FIFO through the core into read FIFO
module ipif_fifo_sequencer
    import ipif_seq_pkg::*;
#(
    parameter int C_DWIDTH      = C_DWIDTH_DEF,
    parameter int C_ACK_TIMEOUT = C_ACK_TIMEOUT_DEF,
    parameter int C_CNT_WIDTH   = C_CNT_WIDTH_DEF
) (
    input  logic                  bus2ip_clk,
    input  logic                  bus2ip_reset,
    ipif_fifo_sequencer_if.master bus
);
    seq_state_t              r_state;
    logic                    r_rdreq;
    logic                    r_wrreq;
    logic                    r_core_start;
    logic                    r_busy;
    logic                    r_err;
    logic [0:C_DWIDTH-1]     r_operand;
    logic [0:C_DWIDTH-1]     r_wdata;
    logic [0:C_CNT_WIDTH-1]  r_words_in;
    logic [0:C_CNT_WIDTH-1]  r_words_out;

    logic w_rd_go;
    logic w_wr_go;
    logic w_tmr_expire;
    logic w_in_req;

    // Transitions into the two acknowledge-waiting states; they also reload the ack timer
    assign w_rd_go  = (r_state == ST_IDLE) && bus.seq_enable && !bus.wfifo2ip_empty;
    assign w_wr_go  = (r_state == ST_WR_HOLD) && !bus.rfifo2ip_full;
    assign w_in_req = is_req_state(r_state);

    ipif_ack_timer #(
        .C_ACK_TIMEOUT (C_ACK_TIMEOUT)
    ) u_ack_timer (
        .clk      (bus2ip_clk),
        .rst      (bus2ip_reset),
        .i_load   (w_rd_go || w_wr_go),
        .i_clear  (!w_in_req),
        .i_tick   (w_in_req),
        .o_expire (w_tmr_expire)
    );

    // Sequencer FSM; every interface output is a register updated alongside the state
    always_ff @(posedge bus2ip_clk or posedge bus2ip_reset) begin
        if (bus2ip_reset) begin
            r_state      <= ST_IDLE;
            r_rdreq      <= 1'b0;
            r_wrreq      <= 1'b0;
            r_core_start <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_operand    <= '0;
            r_wdata      <= '0;
            r_words_in   <= '0;
            r_words_out  <= '0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_go) begin
                        r_state <= ST_RD_REQ;
                        r_rdreq <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RD_REQ: begin
                    // An ack arriving in the expiry cycle still delivers the word
                    if (bus.wfifo2ip_rdack) begin
                        r_operand    <= bus.wfifo2ip_data;
                        r_words_in   <= r_words_in + 1'b1;
                        r_rdreq      <= 1'b0;
                        r_core_start <= 1'b1;
                        r_state      <= ST_START;
                    end else if (w_tmr_expire) begin
                        r_err   <= 1'b1;
                        r_rdreq <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_START: begin
                    r_state <= ST_CORE_WAIT;
                end
                ST_CORE_WAIT: begin
                    if (bus.core_done) begin
                        r_wdata <= bus.core_result;
                        r_state <= ST_WR_HOLD;
                    end
                end
                ST_WR_HOLD: begin
                    if (w_wr_go) begin
                        r_wrreq <= 1'b1;
                        r_state <= ST_WR_REQ;
                    end
                end
                ST_WR_REQ: begin
                    // Full is no longer consulted here: the request is already on the bus
                    if (bus.rfifo2ip_wrack) begin
                        r_words_out <= r_words_out + 1'b1;
                        r_wrreq     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (w_tmr_expire) begin
                        r_err   <= 1'b1;
                        r_wrreq <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rdreq <= 1'b0;
                    r_wrreq <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ip2wfifo_rdreq = r_rdreq;
    assign bus.ip2rfifo_wrreq = r_wrreq;
    assign bus.ip2rfifo_data  = r_wdata;
    assign bus.core_start     = r_core_start;
    assign bus.core_operand   = r_operand;
    assign bus.seq_busy       = r_busy;
    assign bus.seq_err        = r_err;
    assign bus.words_in       = r_words_in;
    assign bus.words_out      = r_words_out;

endmodule

// File: tb/tb_ipif_fifo_sequencer.sv
// tb/tb_ipif_fifo_sequencer.sv - self-checking bench for ipif_fifo_sequencer
module tb_ipif_fifo_sequencer;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int TO = 16;

    logic bus2ip_clk   = 1'b0;
    logic bus2ip_reset = 1'b1;
    always #5 bus2ip_clk = ~bus2ip_clk;

    ipif_fifo_sequencer_if #(.C_DWIDTH(DW), .C_CNT_WIDTH(CW)) bus ();

    ipif_fifo_sequencer #(
        .C_DWIDTH      (DW),
        .C_ACK_TIMEOUT (TO),
        .C_CNT_WIDTH   (CW)
    ) dut (
        .bus2ip_clk   (bus2ip_clk),
        .bus2ip_reset (bus2ip_reset),
        .bus          (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] wq[$];
    logic [DW-1:0] opq[$];
    logic [DW-1:0] resq[$];
    logic [DW-1:0] fixed_res[$];
    logic [DW-1:0] cur_op;
    int rd_lat, wr_lat, core_lat;
    int rd_cnt, wr_cnt, core_cnt;
    int n_rdreq, n_start, exp_in, exp_out;
    int full_period, cyc, busy_run, last_busy_run;
    logic prev_rdreq, prev_start, prev_wrreq;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic env_reset();
        wq.delete(); opq.delete(); resq.delete(); fixed_res.delete();
        rd_cnt = 0; wr_cnt = 0; core_cnt = 0;
        n_rdreq = 0; n_start = 0; exp_in = 0; exp_out = 0;
        full_period = 0; busy_run = 0; last_busy_run = 0;
        prev_rdreq = 1'b0; prev_start = 1'b0; prev_wrreq = 1'b0;
        bus.seq_enable = 1'b0; bus.wfifo2ip_empty = 1'b1;
        bus.wfifo2ip_rdack = 1'b0; bus.wfifo2ip_data = '0;
        bus.rfifo2ip_full = 1'b0; bus.rfifo2ip_wrack = 1'b0;
        bus.core_done = 1'b0; bus.core_result = '0;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        wq.push_back(w);
        bus.wfifo2ip_empty = 1'b0;
    endtask

    // One clock of the FIFO/core environment plus event checks, sampled 1 time unit after the edge
    task automatic cycle();
        logic          full_before;
        logic [DW-1:0] res;
        full_before = bus.rfifo2ip_full;
        @(posedge bus2ip_clk);
        #1;
        cyc++;
        if (bus.wfifo2ip_rdack) begin
            bus.wfifo2ip_rdack = 1'b0;
            check("rdreq_drop_after_ack", 64'(bus.ip2wfifo_rdreq), 64'(0));
            if (wq.size() > 0) opq.push_back(wq.pop_front());
            exp_in++;
            rd_cnt = 0;
        end else if (bus.ip2wfifo_rdreq) begin
            rd_cnt++;
            if (rd_lat != 0 && rd_cnt >= rd_lat && wq.size() > 0) begin
                bus.wfifo2ip_rdack = 1'b1;
                bus.wfifo2ip_data  = wq[0];
            end
        end else begin
            rd_cnt = 0;
        end
        if (bus.ip2wfifo_rdreq && !prev_rdreq) n_rdreq++;

        if (bus.core_done) bus.core_done = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                check("core_operand_held", 64'(bus.core_operand), 64'(cur_op));
                res = (fixed_res.size() > 0) ? fixed_res.pop_front() : DW'($urandom);
                bus.core_done   = 1'b1;
                bus.core_result = res;
                resq.push_back(res);
            end
        end
        if (bus.core_start) begin
            check("core_start_single_cycle", 64'(prev_start), 64'(0));
            n_start++;
            if (opq.size() == 0) begin
                check("start_without_operand", 64'(opq.size()), 64'(1));
            end else begin
                cur_op = opq.pop_front();
                check("core_operand", 64'(bus.core_operand), 64'(cur_op));
            end
            core_cnt = core_lat;
        end

        if (bus.rfifo2ip_wrack) begin
            bus.rfifo2ip_wrack = 1'b0;
            check("wrreq_drop_after_ack", 64'(bus.ip2rfifo_wrreq), 64'(0));
            exp_out++;
            wr_cnt = 0;
        end else if (bus.ip2rfifo_wrreq) begin
            if (!prev_wrreq) check("wrreq_issued_while_full", 64'(full_before), 64'(0));
            wr_cnt++;
            if (wr_lat != 0 && wr_cnt >= wr_lat) begin
                bus.rfifo2ip_wrack = 1'b1;
                if (resq.size() == 0)
                    check("rfifo_write_expected", 64'(resq.size()), 64'(1));
                else
                    check("rfifo_data_order", 64'(bus.ip2rfifo_data), 64'(resq.pop_front()));
            end
        end else begin
            wr_cnt = 0;
        end
        bus.rfifo2ip_full = (full_period > 0) ? (((cyc / full_period) % 2) == 1) : 1'b0;

        if (bus.seq_busy) busy_run++;
        else if (busy_run > 0) begin
            last_busy_run = busy_run;
            busy_run = 0;
        end
        prev_rdreq = bus.ip2wfifo_rdreq;
        prev_start = bus.core_start;
        prev_wrreq = bus.ip2rfifo_wrreq;
        bus.wfifo2ip_empty = (wq.size() == 0);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget && !(wq.size() == 0 && !bus.seq_busy && !bus.wfifo2ip_rdack &&
                               !bus.rfifo2ip_wrack && core_cnt == 0)) begin
            cycle();
            n++;
        end
        check({"drain_", tag}, 64'(wq.size() == 0 && !bus.seq_busy), 64'(1));
    endtask

    initial begin
        int n, hi, nw, base_in, base_out;
        cyc = 0;
        env_reset();
        rd_lat = 1; wr_lat = 1; core_lat = 1;
        repeat (3) @(posedge bus2ip_clk);
        #1;
        check("reset_rdreq",     64'(bus.ip2wfifo_rdreq), 64'(0));
        check("reset_wrreq",     64'(bus.ip2rfifo_wrreq), 64'(0));
        check("reset_start",     64'(bus.core_start),     64'(0));
        check("reset_busy",      64'(bus.seq_busy),       64'(0));
        check("reset_err",       64'(bus.seq_err),        64'(0));
        check("reset_words_in",  64'(bus.words_in),       64'(0));
        check("reset_words_out", 64'(bus.words_out),      64'(0));
        check("reset_rdata",     64'(bus.ip2rfifo_data),  64'(0));
        check("reset_operand",   64'(bus.core_operand),   64'(0));
        bus2ip_reset = 1'b0;

        // Basic word with 3-cycle acks and a 4-cycle core
        rd_lat = 3; wr_lat = 3; core_lat = 4;
        fixed_res.push_back(32'hA5A5_0001);
        push_word(32'h0000_0064);
        bus.seq_enable = 1'b1;
        drain("basic", 200);
        check("basic_operand",   64'(bus.core_operand),  64'h64);
        check("basic_result",    64'(bus.ip2rfifo_data), 64'hA5A5_0001);
        check("basic_words_in",  64'(bus.words_in),      64'(1));
        check("basic_words_out", 64'(bus.words_out),     64'(1));

        // Minimum latency: IDLE decision plus five busy cycles
        rd_lat = 1; wr_lat = 1; core_lat = 1;
        push_word(DW'($urandom));
        drain("minlat", 100);
        check("min_latency_busy_cycles", 64'(last_busy_run), 64'(5));

        // Randomized streams
        for (int r = 0; r < 3; r++) begin
            rd_lat = $urandom_range(1, 4); wr_lat = $urandom_range(1, 4); core_lat = $urandom_range(1, 6);
            n_start = 0; n_rdreq = 0;
            nw = (r == 0) ? 5 : $urandom_range(2, 6);
            for (int k = 0; k < nw; k++) push_word(DW'($urandom));
            drain("stream", 800);
            check("stream_starts",    64'(n_start),        64'(nw));
            check("stream_rdreqs",    64'(n_rdreq),        64'(nw));
            check("stream_words_in",  64'(bus.words_in),   64'(exp_in));
            check("stream_words_out", 64'(bus.words_out),  64'(exp_out));
            check("stream_results_left", 64'(resq.size()), 64'(0));
        end

        // Backpressure: full toggles every 20 cycles
        full_period = 20; rd_lat = $urandom_range(1, 3); wr_lat = $urandom_range(1, 3); core_lat = 2;
        base_out = exp_out;
        for (int k = 0; k < 8; k++) push_word(DW'($urandom));
        drain("backpressure", 3000);
        full_period = 0;
        check("bp_words_out", 64'(bus.words_out), 64'(base_out + 8));
        check("bp_results_left", 64'(resq.size()), 64'(0));

        // Enable dropped while the core works: that word completes, no new read
        rd_lat = 1; wr_lat = 2; core_lat = 8;
        n_start = 0; n_rdreq = 0; base_out = exp_out;
        for (int k = 0; k < 3; k++) push_word(DW'($urandom));
        n = 0;
        while (n_start == 0 && n < 100) begin cycle(); n++; end
        check("edrop_start_seen", 64'(n_start), 64'(1));
        cycle();
        bus.seq_enable = 1'b0;
        repeat (40) cycle();
        check("edrop_rdreq_count", 64'(n_rdreq),       64'(1));
        check("edrop_words_out",   64'(bus.words_out), 64'(base_out + 1));
        check("edrop_idle",        64'(bus.seq_busy),  64'(0));
        check("edrop_fifo_left",   64'(wq.size()),     64'(2));
        wq.delete();
        bus.wfifo2ip_empty = 1'b1;

        // Read ack withheld: request abandoned after C_ACK_TIMEOUT cycles
        rd_lat = 0; base_in = exp_in;
        push_word(DW'($urandom));
        bus.seq_enable = 1'b1;
        n = 0;
        while (!bus.ip2wfifo_rdreq && n < 50) begin cycle(); n++; end
        bus.seq_enable = 1'b0;
        hi = 0; n = 0;
        while (bus.ip2wfifo_rdreq && n < 100) begin hi++; cycle(); n++; end
        check("timeout_rdreq_cycles", 64'(hi),           64'(TO));
        check("timeout_err",          64'(bus.seq_err),  64'(1));
        check("timeout_words_in",     64'(bus.words_in), 64'(base_in));
        check("timeout_idle",         64'(bus.seq_busy), 64'(0));
        wq.delete();
        bus.wfifo2ip_empty = 1'b1;

        // Reset asserted between edges while a write request is pending
        rd_lat = 1; core_lat = 1; wr_lat = 0;
        push_word(DW'($urandom));
        bus.seq_enable = 1'b1;
        n = 0;
        while (!bus.ip2rfifo_wrreq && n < 100) begin cycle(); n++; end
        check("rst_reached_wr_req", 64'(bus.ip2rfifo_wrreq), 64'(1));
        bus.seq_enable = 1'b0;
        #2;
        bus2ip_reset = 1'b1;
        #1;
        check("rst_wrreq",     64'(bus.ip2rfifo_wrreq), 64'(0));
        check("rst_words_in",  64'(bus.words_in),       64'(0));
        check("rst_words_out", 64'(bus.words_out),      64'(0));
        check("rst_err",       64'(bus.seq_err),        64'(0));
        check("rst_busy",      64'(bus.seq_busy),       64'(0));
        check("rst_rdata",     64'(bus.ip2rfifo_data),  64'(0));
        env_reset();
        @(posedge bus2ip_clk);
        #1;
        bus2ip_reset = 1'b0;
        cycle();
        cycle();
        check("post_rst_busy",  64'(bus.seq_busy),       64'(0));
        check("post_rst_rdreq", 64'(bus.ip2wfifo_rdreq), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ipif_fifo_sequencer.md
# ipif_fifo_sequencer

Controller that moves operand words through a compute core using the IPIF FIFO services. It pulls one word from the write FIFO with an ip2wfifo_rdreq/wfifo2ip_rdack handshake and launches the core (integer divider or huffman encoder) with a start pulse. It then pushes the core result into the read FIFO with an ip2rfifo_wrreq/rfifo2ip_wrack handshake, honouring rfifo2ip_full. The block sits inside user_logic, between the IPIF FIFO ports and the datapath core.

## Interface
- C_DWIDTH, 32, FIFO and core data width
- C_ACK_TIMEOUT, 16, cycles to wait for rdack/wrack before abandoning the request (≥2)
- C_CNT_WIDTH, 16, width of word counters

Ports (IPIF bit order [0:N-1], bit 0 = MSB):
- bus2ip_clk  in  1  sole clock, rising edge
- bus2ip_reset  in  1  asynchronous, active-high reset
- seq_enable  in  1  run enable from a control register
- wfifo2ip_empty  in  1  write FIFO empty
- wfifo2ip_rdack  in  1  read acknowledge; data valid this cycle
- wfifo2ip_data  in  C_DWIDTH  write FIFO data
- ip2wfifo_rdreq  out  1  read request, held until rdack
- rfifo2ip_full  in  1  read FIFO full
- rfifo2ip_wrack  in  1  write acknowledge
- ip2rfifo_wrreq  out  1  write request, held until wrack
- ip2rfifo_data  out  C_DWIDTH  result word, stable while wrreq high
- core_start  out  1  one-cycle start pulse
- core_operand  out  C_DWIDTH  operand, stable from start until done
- core_done  in  1  one-cycle completion pulse
- core_result  in  C_DWIDTH  result, valid with core_done
- seq_busy  out  1  state ≠ IDLE
- seq_err  out  1  sticky ack-timeout flag; cleared only by reset
- words_in  out  C_CNT_WIDTH  operands accepted (wraps)
- words_out  out  C_CNT_WIDTH  results written (wraps)

## Operation
- FSM states: IDLE, RD_REQ, START, CORE_WAIT, WR_HOLD, WR_REQ.
- IDLE: if seq_enable && !wfifo2ip_empty, go to RD_REQ.
- RD_REQ: ip2wfifo_rdreq=1.
  - On rdack: capture wfifo2ip_data into core_operand, increment words_in, go to START.
  - Timeout: set seq_err, go to IDLE.
- START: core_start=1 for exactly one cycle, then go to CORE_WAIT.
- CORE_WAIT: on core_done, capture core_result into ip2rfifo_data, go to WR_HOLD.
- WR_HOLD: wait while rfifo2ip_full; when !full, go to WR_REQ.
- WR_REQ: ip2rfifo_wrreq=1.
  - On wrack: increment words_out, go to IDLE.
  - Timeout: set seq_err, drop the word, go to IDLE.
- Ack timer: counts cycles in RD_REQ/WR_REQ and clears on state entry. Timeout fires when the count reaches C_ACK_TIMEOUT-1 with no ack.
- seq_enable dropped mid-word: the current word completes through WR_REQ, and no new read starts.
- rfifo2ip_full rising during WR_REQ is ignored: the request is already issued, so hold until wrack.
- rdack/wrack/core_done outside their states are ignored.
- Counters wrap modulo 2^C_CNT_WIDTH.
- Only one word is in flight at a time; no pipelining.

## Timing
- Reset (async assert, sync release): state IDLE; every output 0, including data outputs, counters and seq_err.
- Reset mid-operation aborts at once: the word is lost, requests drop the same instant.
- All outputs are registered.
- Minimum per-word latency, from the IDLE decision with 1-cycle acks and 1-cycle core: 6 cycles.
  - IDLE→RD_REQ 1, rdack 1, START 1, done 1, WR_HOLD 1, wrack 1.
- rdreq and wrreq deassert in the cycle after the ack edge.
- A second rdreq never starts in the cycle a wrack is taken; IDLE is always visited.
- rdack and timeout in the same cycle: the ack wins.

## Structure
- Shared package ipif_seq_pkg holds:
  - state enum (3-bit encoding: IDLE=0, RD_REQ=1, START=2, CORE_WAIT=3, WR_HOLD=4, WR_REQ=5)
  - default parameter constants
- One sub-module, ipif_ack_timer: a loadable down-counter with clear and expire outputs, instantiated once and shared by RD_REQ/WR_REQ.

## Test plan
- Basic word: 3-cycle acks, core_done 4 cycles after start, operand 0x0000_0064 → core_operand=0x64; result 0xA5A5_0001 on ip2rfifo_data; words_in=words_out=1.
- Stream: 5 words, FIFO non-empty, enable high → 5 start pulses; words_out=5; each rdreq exactly once per word.
- Backpressure: rfifo2ip_full toggling 20 high/20 low cycles → wrreq never asserts while full in WR_HOLD; all results written in order.
- Timeout: C_ACK_TIMEOUT=16, rdack withheld → rdreq drops after 16 cycles; seq_err=1; words_in unchanged; FSM returns to IDLE.
- Enable drop: deassert seq_enable in CORE_WAIT → current result written; no further rdreq.
- Reset mid-WR_REQ: assert bus2ip_reset between edges → wrreq, counters and seq_err go to 0 immediately; state is IDLE after release.
